// File: rtl/store_commit_queue.sv
// Store commit queue: buffers retired stores in program order, drains them one per
// memory handshake, forwards queued data to loads and runs a fence/drain handshake.
module store_commit_queue #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid_a,
    input  logic [ADDR_W-1:0] st_addr_a,
    input  logic [DATA_W-1:0] st_data_a,
    input  logic              st_valid_b,
    input  logic [ADDR_W-1:0] st_addr_b,
    input  logic [DATA_W-1:0] st_data_b,
    output logic              st_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    input  logic              fence_req,
    output logic              fence_done,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic              enq_a, enq_b, deq;
    logic [1:0]        enq_n;
    logic [PTR_W-1:0]  b_ptr;
    logic [CNT_W-1:0]  free_slots;

    // Held-request tracking, used only to check stability of a stalled head.
    logic              stall_q;
    logic [ADDR_W-1:0] stall_addr_q;
    logic [DATA_W-1:0] stall_data_q;

    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign enq_a      = st_ready && st_valid_a;
    assign enq_b      = st_ready && st_valid_b;
    assign enq_n      = {1'b0, enq_a} + {1'b0, enq_b};
    // B follows A when both commit; a lone B takes the tail slot itself.
    assign b_ptr      = wr_ptr_q + PTR_W'(enq_a);

    assign mem_req_valid = (count_q != '0);
    assign mem_req_addr  = addr_q[rd_ptr_q];
    assign mem_req_data  = data_q[rd_ptr_q];
    assign deq           = mem_req_valid && mem_req_ready;
    assign count         = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
        count_d  = count_q + CNT_W'(enq_n) - CNT_W'(deq);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry storage has no reset; count/pointers alone define which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (enq_a) begin
                addr_q[wr_ptr_q] <= st_addr_a;
                data_q[wr_ptr_q] <= st_data_a;
            end
            if (enq_b) begin
                addr_q[b_ptr] <= st_addr_b;
                data_q[b_ptr] <= st_data_b;
            end
        end
    end

    // Oldest-to-youngest scan so the last match (youngest store) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fence_req) state_d = S_DRAIN;
            S_DRAIN: begin
                // Leave as soon as the last entry is handed to memory.
                if ((count_q == '0) || ((count_q == CNT_W'(1)) && deq)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        st_ready   = (state_q == S_IDLE) && (free_slots >= CNT_W'(2));
        fence_done = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= mem_req_valid && !mem_req_ready;
        end
        stall_addr_q <= mem_req_addr;
        stall_data_q <= mem_req_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= CNT_W'(DEPTH));
            assert (st_ready || !(st_valid_a || st_valid_b));
            if (stall_q) begin
                assert (mem_req_valid && (mem_req_addr == stall_addr_q)
                        && (mem_req_data == stall_data_q));
            end
        end
    end

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue: enqueue/drain order, back-pressure, pointer
// wrap, youngest-match forwarding, fence handshake and reset during a drain.
module tb_store_commit_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid_a, st_valid_b;
    logic [31:0] st_addr_a, st_addr_b, st_data_a, st_data_b;
    logic        st_ready;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [31:0] ld_addr, ld_data;
    logic        ld_hit;
    logic        fence_req, fence_done;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_commit_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid_a    (st_valid_a),
        .st_addr_a     (st_addr_a),
        .st_data_a     (st_data_a),
        .st_valid_b    (st_valid_b),
        .st_addr_b     (st_addr_b),
        .st_data_b     (st_data_b),
        .st_ready      (st_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready),
        .ld_addr       (ld_addr),
        .ld_hit        (ld_hit),
        .ld_data       (ld_data),
        .fence_req     (fence_req),
        .fence_done    (fence_done),
        .count         (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [31:0] a, input logic [31:0] d);
        st_valid_a = v;
        st_addr_a  = a;
        st_data_a  = d;
    endtask

    task automatic set_b(input logic v, input logic [31:0] a, input logic [31:0] d);
        st_valid_b = v;
        st_addr_b  = a;
        st_data_b  = d;
    endtask

    initial begin
        reset = 1'b1;
        set_a(1'b0, '0, '0);
        set_b(1'b0, '0, '0);
        mem_req_ready = 1'b0;
        ld_addr       = '0;
        fence_req     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_st_ready", st_ready, 1);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_fence_done", fence_done, 0);
        check("rst_ld_hit", ld_hit, 0);
        check("rst_ld_data", ld_data, 0);
        check("rst_count", count, 0);

        // 1: dual commit, immediate drain in order
        set_a(1'b1, 32'h10, 32'hAA);
        set_b(1'b1, 32'h14, 32'hBB);
        mem_req_ready = 1'b1;
        tick();
        set_a(1'b0, '0, '0);
        set_b(1'b0, '0, '0);
        #1;
        check("t1_count2", count, 2);
        check("t1_valid", mem_req_valid, 1);
        check("t1_addr0", mem_req_addr, 32'h10);
        check("t1_data0", mem_req_data, 32'hAA);
        tick();
        check("t1_count1", count, 1);
        check("t1_addr1", mem_req_addr, 32'h14);
        check("t1_data1", mem_req_data, 32'hBB);
        tick();
        check("t1_count0", count, 0);
        check("t1_idle_valid", mem_req_valid, 0);

        // 2: back-pressure, fill to DEPTH (entries land at indices 2,3,0,1)
        mem_req_ready = 1'b0;
        set_a(1'b1, 32'h30, 32'h1);
        set_b(1'b1, 32'h34, 32'h2);
        tick();
        set_a(1'b1, 32'h38, 32'h3);
        set_b(1'b1, 32'h3C, 32'h4);
        #1;
        check("t2_count2", count, 2);
        check("t2_ready_at2", st_ready, 1);
        tick();
        set_a(1'b0, '0, '0);
        set_b(1'b0, '0, '0);
        #1;
        check("t2_count4", count, 4);
        check("t2_ready_full", st_ready, 0);
        check("t2_head_addr", mem_req_addr, 32'h30);
        tick();
        check("t2_stall_addr", mem_req_addr, 32'h30);
        check("t2_stall_data", mem_req_data, 32'h1);
        check("t2_stall_count", count, 4);

        // 3: drain to 3, same-cycle dequeue must not raise st_ready, then wrap
        mem_req_ready = 1'b1;
        tick();
        check("t3_count3", count, 3);
        check("t3_ready_at3_deq", st_ready, 0);
        tick();
        check("t3_count2", count, 2);
        check("t3_ready_at2", st_ready, 1);
        check("t3_wrap_head", mem_req_addr, 32'h38);
        tick();
        tick();
        check("t3_empty", count, 0);

        // 4: forwarding, youngest match wins; new entries visible next cycle
        mem_req_ready = 1'b0;
        set_a(1'b1, 32'h20, 32'h1);
        set_b(1'b1, 32'h24, 32'h2);
        tick();
        set_a(1'b1, 32'h20, 32'h3);
        set_b(1'b0, '0, '0);
        ld_addr = 32'h20;
        #1;
        check("t4_fwd_before", ld_data, 32'h1);
        tick();
        set_a(1'b0, '0, '0);
        #1;
        check("t4_count3", count, 3);
        check("t4_hit20", ld_hit, 1);
        check("t4_data20", ld_data, 32'h3);
        ld_addr = 32'h24;
        #1;
        check("t4_data24", ld_data, 32'h2);
        ld_addr = 32'h28;
        #1;
        check("t4_hit28", ld_hit, 0);
        check("t4_data28", ld_data, 0);

        // 5: fence with toggling ready
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("t5_drain_rdy_a", st_ready, 0);
        check("t5_head_a", mem_req_addr, 32'h20);
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("t5_count2", count, 2);
        check("t5_drain_rdy_b", st_ready, 0);
        check("t5_done_b", fence_done, 0);
        tick();
        mem_req_ready = 1'b1;
        #1;
        check("t5_drain_rdy_c", st_ready, 0);
        check("t5_head_c", mem_req_addr, 32'h24);
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("t5_count1", count, 1);
        check("t5_done_d", fence_done, 0);
        tick();
        mem_req_ready = 1'b1;
        #1;
        check("t5_drain_rdy_e", st_ready, 0);
        check("t5_done_e", fence_done, 0);
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("t5_done_pulse", fence_done, 1);
        check("t5_done_count", count, 0);
        check("t5_done_rdy", st_ready, 0);
        tick();
        check("t5_done_clear", fence_done, 0);
        check("t5_idle_rdy", st_ready, 1);

        // Fence on an empty queue: IDLE -> DRAIN -> DONE; fence in DONE ignored
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        #1;
        check("t5e_drain_done", fence_done, 0);
        check("t5e_drain_rdy", st_ready, 0);
        tick();
        fence_req = 1'b1;
        #1;
        check("t5e_done", fence_done, 1);
        tick();
        fence_req = 1'b0;
        #1;
        check("t5e_after_done", fence_done, 0);
        tick();
        check("t5e_ignored_rdy", st_ready, 1);
        check("t5e_ignored_done", fence_done, 0);

        // 6: reset during DRAIN with two entries queued
        set_a(1'b1, 32'h50, 32'h7);
        set_b(1'b1, 32'h54, 32'h8);
        tick();
        set_a(1'b0, '0, '0);
        set_b(1'b0, '0, '0);
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        #1;
        check("t6_drain_count", count, 2);
        check("t6_drain_rdy", st_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ld_addr = 32'h50;
        #1;
        check("t6_count", count, 0);
        check("t6_valid", mem_req_valid, 0);
        check("t6_rdy", st_ready, 1);
        check("t6_done", fence_done, 0);
        check("t6_ld_hit", ld_hit, 0);
        tick();
        check("t6_done_later", fence_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
